// File: rtl/conf_loader.sv
// Frame parser and atomic commit controller for the UART configuration path.
// Collects SYNC, CONF_PAR_NUM payload bytes and a checksum, then loads them into conf_out inside the apply_en window.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for SYNC_BYTE, other bytes ignored
// S_PAYLOAD | storing payload bytes into shadow, inter-byte timer running
// S_CHECK   | waiting for checksum byte, inter-byte timer running
// S_PENDING | frame valid, waiting for apply_en to commit shadow
module conf_loader #(
  parameter int          CONF_PAR_NUM = 5,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          TIMEOUT_MAX  = 2080
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  input  logic                      apply_en,
  output logic [8*CONF_PAR_NUM-1:0] conf_out,
  output logic                      upd,
  output logic                      frame_err,
  output logic                      ovr,
  output logic                      busy
);

  localparam int IDX_W = (CONF_PAR_NUM > 1) ? $clog2(CONF_PAR_NUM) : 1;
  localparam int TW    = $clog2(TIMEOUT_MAX + 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CONF_PAR_NUM - 1);
  localparam logic [TW-1:0]    TIMER_END = TW'(TIMEOUT_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_CHECK,
    S_PENDING
  } state_t;

  state_t                    state_q, state_d;
  logic [8*CONF_PAR_NUM-1:0] shadow_q;
  logic [7:0]                sum_q;
  logic [IDX_W-1:0]          idx_q;
  logic [TW-1:0]             timer_q;

  logic       start, store, tick, err, commit, drop;
  logic [7:0] chk_sum;

  assign chk_sum = sum_q + rx_data;
  assign busy    = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    store   = 1'b0;
    tick    = 1'b0;
    err     = 1'b0;
    commit  = 1'b0;
    drop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          start   = 1'b1;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        // a byte landing on the expiry cycle takes priority over the timeout
        if (rx_valid) begin
          store = 1'b1;
          if (idx_q == IDX_LAST) state_d = S_CHECK;
        end else if (timer_q == TIMER_END) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end else begin
          tick = 1'b1;
        end
      end
      S_CHECK: begin
        if (rx_valid) begin
          if (chk_sum == 8'h00) begin
            state_d = S_PENDING;
          end else begin
            err     = 1'b1;
            state_d = S_IDLE;
          end
        end else if (timer_q == TIMER_END) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end else begin
          tick = 1'b1;
        end
      end
      S_PENDING: begin
        drop = rx_valid;
        if (apply_en) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      conf_out  <= '0;
      shadow_q  <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      upd       <= 1'b0;
      frame_err <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      state_q   <= state_d;
      upd       <= commit;
      frame_err <= err;
      ovr       <= drop;
      if (commit) conf_out <= shadow_q;
      if (start) begin
        idx_q   <= '0;
        sum_q   <= '0;
        timer_q <= '0;
      end
      if (store) begin
        for (int i = 0; i < CONF_PAR_NUM; i++) begin
          if (idx_q == IDX_W'(i)) shadow_q[8*i +: 8] <= rx_data;
        end
        sum_q   <= sum_q + rx_data;
        timer_q <= '0;
        if (idx_q != IDX_LAST) idx_q <= idx_q + IDX_W'(1);
      end
      if (tick) timer_q <= timer_q + TW'(1);
    end
  end

endmodule

// File: tb/tb_conf_loader.sv
// Directed bench for conf_loader: framing, checksum, timeout boundary, overrun, deferred commit and reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge or just after reset assertion.
module tb_conf_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        apply_en;
  logic [39:0] conf_out;
  logic        upd;
  logic        frame_err;
  logic        ovr;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int upd_seen = 0;
  int err_seen = 0;
  int ovr_seen = 0;
  int upd_mark, err_mark, ovr_mark;

  conf_loader #(
    .CONF_PAR_NUM(5),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_MAX (2080)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .apply_en (apply_en),
    .conf_out (conf_out),
    .upd      (upd),
    .frame_err(frame_err),
    .ovr      (ovr),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (upd)       upd_seen++;
    if (frame_err) err_seen++;
    if (ovr)       ovr_seen++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called at a falling edge; byte is sampled on the next rising edge, returns at the following falling edge
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] p0, p1, p2, p3, p4, c);
    send_byte(8'hA5);
    send_byte(p0);
    send_byte(p1);
    send_byte(p2);
    send_byte(p3);
    send_byte(p4);
    send_byte(c);
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    apply_en = 1'b0;
    idle(2);
    chk("rst_conf", conf_out, 40'h0);
    chk("rst_upd", upd, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    chk("rst_ovr", ovr, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // 1: good frame, window already open
    apply_en = 1'b1;
    upd_mark = upd_seen;
    send_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h10);
    chk("t1_pending_busy", busy, 1'b1);
    chk("t1_no_upd_yet", upd, 1'b0);
    idle(1);
    chk("t1_upd", upd, 1'b1);
    chk("t1_conf", conf_out, 40'h50_40_30_20_10);
    chk("t1_idle", busy, 1'b0);
    idle(1);
    chk("t1_upd_count", upd_seen - upd_mark, 1);

    // 2: bad checksum
    upd_mark = upd_seen;
    send_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h11);
    chk("t2_err", frame_err, 1'b1);
    chk("t2_idle", busy, 1'b0);
    idle(1);
    chk("t2_err_pulse", frame_err, 1'b0);
    idle(2);
    chk("t2_no_upd", upd_seen - upd_mark, 0);
    chk("t2_conf_kept", conf_out, 40'h50_40_30_20_10);

    // 3: garbage then truncated frame, timeout boundary
    err_mark = err_seen;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    idle(2080);
    chk("t3_no_err_early", err_seen - err_mark, 0);
    chk("t3_busy_before_expiry", busy, 1'b1);
    idle(1);
    chk("t3_timeout_err", frame_err, 1'b1);
    chk("t3_idle", busy, 1'b0);
    chk("t3_conf_kept", conf_out, 40'h50_40_30_20_10);

    // 4: commit deferred until apply_en, overruns while pending
    apply_en = 1'b0;
    idle(2);
    upd_mark = upd_seen;
    ovr_mark = ovr_seen;
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hF1);
    idle(2);
    chk("t4_pending", busy, 1'b1);
    send_byte(8'h77);
    chk("t4_ovr1", ovr, 1'b1);
    idle(1);
    chk("t4_ovr1_pulse", ovr, 1'b0);
    send_byte(8'hA5);
    chk("t4_ovr2", ovr, 1'b1);
    idle(1000);
    chk("t4_still_pending", busy, 1'b1);
    chk("t4_no_upd_wait", upd_seen - upd_mark, 0);
    chk("t4_conf_wait", conf_out, 40'h50_40_30_20_10);
    apply_en = 1'b1;
    idle(1);
    chk("t4_upd", upd, 1'b1);
    chk("t4_conf", conf_out, 40'h05_04_03_02_01);
    chk("t4_ovr_count", ovr_seen - ovr_mark, 2);

    // 4b: apply_en and rx_valid on the same cycle
    apply_en = 1'b0;
    idle(1);
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h01);
    apply_en = 1'b1;
    send_byte(8'h99);
    chk("t4b_upd", upd, 1'b1);
    chk("t4b_ovr", ovr, 1'b1);
    chk("t4b_conf", conf_out, 40'h55_44_33_22_11);
    idle(1);

    // 5: bytes landing exactly on the expiry cycle, checksum wrap
    err_mark = err_seen;
    send_byte(8'hA5);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'hFF);
    idle(2080);
    send_byte(8'hFF);
    idle(2080);
    send_byte(8'h05);
    chk("t5_pending", busy, 1'b1);
    idle(1);
    chk("t5_upd", upd, 1'b1);
    chk("t5_conf", conf_out, 40'hFF_FF_FF_FF_FF);
    chk("t5_no_err", err_seen - err_mark, 0);

    // 6: reset mid-payload and while pending
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h20);
    rst_n = 1'b0;
    #1;
    chk("t6a_conf", conf_out, 40'h0);
    chk("t6a_busy", busy, 1'b0);
    chk("t6a_flags", {upd, frame_err, ovr}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    apply_en = 1'b0;
    idle(1);
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hF1);
    chk("t6b_pending", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6b_busy", busy, 1'b0);
    chk("t6b_conf", conf_out, 40'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_en = 1'b1;
    idle(1);
    chk("t6b_stays_idle", {busy, upd}, 2'b00);
    send_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h10);
    idle(1);
    chk("t6c_upd", upd, 1'b1);
    chk("t6c_conf", conf_out, 40'h50_40_30_20_10);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
